im_fetch_unit: RTL and testbench

- Initiator for the instruction-memory port.
- Holds the PC, issues single-word read requests (I_valid strobe + instr_REn) and waits a fixed response latency.
- Captures R_instr/I_err and presents fetched instructions to decode over a valid/ready handshake.
- Handles redirects, such as branch or jump, and latches fetch faults.

---
 rtl/im_pkg.sv | 40 ++++
 rtl/im_fetch_unit_if.sv | 22 ++
 rtl/im_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_im_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-memory fetch path:
// fetch FSM states, IM request bundle, debug view and the address range check.
package im_pkg;

  localparam logic [31:0] IM_BASE_ADDR = 32'h0100_0000;
  localparam int unsigned IM_WORDS     = 1024;
  localparam int unsigned INSTR_W      = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        addr;
    logic               ren;
    logic               wen;
    logic [INSTR_W-1:0] wdata;
    logic               valid;
    logic               clr;
  } im_req_t;

  typedef struct packed {
    fetch_state_t state;
    logic         pc_in_range;
  } fetch_dbg_t;

  // True when addr is a word-aligned address inside [base, base + words*4).
  function automatic logic im_range_chk(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned words);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'(words) << 2);
    return (addr >= base) && ({1'b0, addr} < lim) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/im_fetch_unit_if.sv
// Instruction-memory port bundle: the fetch unit is the master, the memory the slave.
// Handshake: I_valid is a one-cycle strobe with instr_REn/instr_Raddr; R_instr/I_err are valid a fixed latency later.
interface im_fetch_unit_if;
  logic [31:0] instr_Raddr;
  logic        instr_REn;
  logic        instr_WEn;
  logic [31:0] W_instr;
  logic        I_valid;
  logic        I_clr;
  logic [31:0] R_instr;
  logic        I_err;

  modport master (
    output instr_Raddr, instr_REn, instr_WEn, W_instr, I_valid, I_clr,
    input  R_instr, I_err
  );

  modport slave (
    input  instr_Raddr, instr_REn, instr_WEn, W_instr, I_valid, I_clr,
    output R_instr, I_err
  );
endinterface

// File: rtl/im_fetch_unit.sv
// Single-outstanding instruction fetch: strobes one IM read, waits RSP_LAT cycles, hands the word to decode.
// Optional local PC bound check when IM_FETCH_BOUND_CHK_EN is defined.
module im_fetch_unit
  import im_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] IM_BASE  = 32'h0100_0000,
  parameter int unsigned IM_WORDS = 1024,
  parameter int unsigned RSP_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  im_fetch_unit_if.master      im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [31:0]          out_pc,
  output logic                 fetch_err,
  output logic [31:0]          err_addr,
  input  logic                 err_clr,
  output fetch_dbg_t           dbg_o
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic [INSTR_W-1:0] oi_q, oi_d;
  logic [31:0]        opc_q, opc_d;
  logic               ferr_q, ferr_d;
  logic [31:0]        eaddr_q, eaddr_d;
  im_req_t            req;
  logic               pc_in_range;
  logic               bound_fault;

  assign pc_in_range = im_range_chk(pc_q, IM_BASE, IM_WORDS);

`ifdef IM_FETCH_BOUND_CHK_EN
  assign bound_fault = !pc_in_range;
`else
  assign bound_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      oi_q    <= '0;
      opc_q   <= '0;
      ferr_q  <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      oi_q    <= oi_d;
      opc_q   <= opc_d;
      ferr_q  <= ferr_d;
      eaddr_q <= eaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    oi_d    = oi_q;
    opc_d   = opc_q;
    ferr_d  = ferr_q;
    eaddr_d = eaddr_q;
    req     = '0;

    case (state_q)
      IDLE: begin
        if (fetch_en && !ferr_q) state_d = REQ;
      end
      REQ: begin
        if (bound_fault) begin
          ferr_d  = 1'b1;
          eaddr_d = pc_q;
          state_d = ERR;
        end else begin
          req.valid = 1'b1;
          req.ren   = 1'b1;
          req.addr  = pc_q;
          cnt_d     = 3'(RSP_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (im.I_err) begin
            ferr_d  = 1'b1;
            eaddr_d = pc_q;
            state_d = ERR;
          end else begin
            oi_d    = im.R_instr;
            opc_d   = pc_q;
            ov_d    = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = fetch_en ? REQ : IDLE;
        end
      end
      ERR: begin
        if (err_clr) begin
          ferr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins: any in-flight response or held word becomes stale.
    // In ERR only the PC moves; leaving ERR still needs err_clr.
    if (redirect_valid) begin
      pc_d = redirect_pc;
      ov_d = 1'b0;
      if (state_q != ERR) begin
        state_d = IDLE;
        cnt_d   = '0;
        oi_d    = oi_q;
        opc_d   = opc_q;
        ferr_d  = ferr_q;
        eaddr_d = eaddr_q;
      end
    end
  end

  assign im.instr_Raddr = req.addr;
  assign im.instr_REn   = req.ren;
  assign im.instr_WEn   = req.wen;
  assign im.W_instr     = req.wdata;
  assign im.I_valid     = req.valid;
  assign im.I_clr       = req.clr;

  assign out_valid = ov_q;
  assign out_instr = oi_q;
  assign out_pc    = opc_q;
  assign fetch_err = ferr_q;
  assign err_addr  = eaddr_q;

  assign dbg_o.state       = state_q;
  assign dbg_o.pc_in_range = pc_in_range;

endmodule

// File: tb/tb_im_fetch_unit.sv
// Directed bench for im_fetch_unit: one instance with RSP_LAT=1, one with RSP_LAT=3,
// each behind a small IM model that returns a fixed pattern and flags out-of-range/misaligned reads.
module tb_im_fetch_unit;
  import im_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with RSP_LAT=1 ----------------
  logic        fe1 = 1'b0, rv1 = 1'b0, rdy1 = 1'b1, ec1 = 1'b0;
  logic [31:0] rpc1 = '0;
  logic        ov1, ferr1;
  logic [31:0] oi1, opc1, eaddr1;
  fetch_dbg_t  dbg1;
  im_fetch_unit_if bus1 ();

  im_fetch_unit #(.RSP_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fe1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .im(bus1),
    .out_valid(ov1), .out_ready(rdy1), .out_instr(oi1), .out_pc(opc1),
    .fetch_err(ferr1), .err_addr(eaddr1), .err_clr(ec1), .dbg_o(dbg1)
  );

  // ---------------- DUT with RSP_LAT=3 ----------------
  logic        fe3 = 1'b0, rdy3 = 1'b1;
  logic        ov3, ferr3;
  logic [31:0] oi3, opc3, eaddr3;
  fetch_dbg_t  dbg3;
  im_fetch_unit_if bus3 ();

  im_fetch_unit #(.RSP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fe3),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .im(bus3),
    .out_valid(ov3), .out_ready(rdy3), .out_instr(oi3), .out_pc(opc3),
    .fetch_err(ferr3), .err_addr(eaddr3), .err_clr(1'b0), .dbg_o(dbg3)
  );

  // ---------------- IM models ----------------
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return (a == 32'h0100_0000) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic im_bad(input logic [31:0] a);
    return (a < 32'h0100_0000) || (a >= 32'h0100_1000) || (a[1:0] != 2'b00);
  endfunction

  logic [32:0] p1, p3a, p3b, p3c;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0; p3a <= '0; p3b <= '0; p3c <= '0;
    end else begin
      p1  <= {bus1.I_valid, bus1.instr_Raddr};
      p3a <= {bus3.I_valid, bus3.instr_Raddr};
      p3b <= p3a;
      p3c <= p3b;
    end
  end

  assign bus1.R_instr = p1[32]  ? im_word(p1[31:0])  : 32'hBAD0_BAD0;
  assign bus1.I_err   = p1[32]  & im_bad(p1[31:0]);
  assign bus3.R_instr = p3c[32] ? im_word(p3c[31:0]) : 32'hBAD0_BAD0;
  assign bus3.I_err   = p3c[32] & im_bad(p3c[31:0]);

  int n_stb1 = 0, n_stb3 = 0;
  always @(posedge clk) begin
    if (rst_n && bus1.I_valid === 1'b1) n_stb1 <= n_stb1 + 1;
    if (rst_n && bus3.I_valid === 1'b1) n_stb3 <= n_stb3 + 1;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int s;
  initial begin
    fe1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov",     32'(ov1), 32'h0);
    check("rst_oi",     oi1, 32'h0);
    check("rst_opc",    opc1, 32'h0);
    check("rst_ferr",   32'(ferr1), 32'h0);
    check("rst_eaddr",  eaddr1, 32'h0);
    check("rst_ival",   32'(bus1.I_valid), 32'h0);
    check("rst_ren",    32'(bus1.instr_REn), 32'h0);
    check("rst_raddr",  bus1.instr_Raddr, 32'h0);
    check("rst_ties",   {29'h0, bus1.instr_WEn, bus1.I_clr, 1'b0}, 32'h0);
    check("rst_wdata",  bus1.W_instr, 32'h0);
    check("rst_state",  32'(dbg1.state), 32'(IDLE));
    @(negedge clk) rst_n = 1'b1;

    // first fetch: strobe at cycle 1, data at cycle 3
    step(); check("c1_ival", 32'(bus1.I_valid), 32'h1);
    check("c1_ren",   32'(bus1.instr_REn), 32'h1);
    check("c1_addr",  bus1.instr_Raddr, 32'h0100_0000);
    step(); check("c2_ival", 32'(bus1.I_valid), 32'h0);
    check("c2_ov",    32'(ov1), 32'h0);
    rdy1 = 1'b0;
    step(); check("c3_ov", 32'(ov1), 32'h1);
    check("c3_oi",    oi1, 32'hDEAD_BEEF);
    check("c3_opc",   opc1, 32'h0100_0000);

    // backpressure: held stable, no new strobe
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_ov",  32'(ov1), 32'h1);
      check("bp_oi",  oi1, 32'hDEAD_BEEF);
      check("bp_opc", opc1, 32'h0100_0000);
    end
    check("bp_nstb", 32'(n_stb1), 32'd1);
    rdy1 = 1'b1;
    step(); check("c8_ival", 32'(bus1.I_valid), 32'h1);
    check("c8_addr",  bus1.instr_Raddr, 32'h0100_0004);
    check("c8_ov",    32'(ov1), 32'h0);

    // redirect during WAIT drops the response
    step(); check("c9_state", 32'(dbg1.state), 32'(WAIT));
    rv1 = 1'b1; rpc1 = 32'h0100_0100;
    step(); rv1 = 1'b0;
    check("c10_state", 32'(dbg1.state), 32'(IDLE));
    check("c10_ov",    32'(ov1), 32'h0);
    check("c10_ferr",  32'(ferr1), 32'h0);
    step(); check("c11_addr", bus1.instr_Raddr, 32'h0100_0100);
    check("c11_ival", 32'(bus1.I_valid), 32'h1);
    step(); ec1 = 1'b1;
    step(); ec1 = 1'b0;
    check("c13_ov",   32'(ov1), 32'h1);
    check("c13_oi",   oi1, 32'h0100_FEFF);
    check("c13_opc",  opc1, 32'h0100_0100);
    check("c13_ferr", 32'(ferr1), 32'h0);

    // redirect in the REQ cycle discards the strobe just issued
    step(); check("c14_addr", bus1.instr_Raddr, 32'h0100_0104);
    rv1 = 1'b1; rpc1 = 32'h0100_0FFC;
    step(); rv1 = 1'b0;
    check("c15_state", 32'(dbg1.state), 32'(IDLE));
    step(); check("c16_addr", bus1.instr_Raddr, 32'h0100_0FFC);
    step(2); check("c18_ov", 32'(ov1), 32'h1);
    check("c18_oi",   oi1, 32'h0FFC_F003);
    check("c18_opc",  opc1, 32'h0100_0FFC);

    // next word falls off the end of IM: I_err fault
    step(); check("c19_addr", bus1.instr_Raddr, 32'h0100_1000);
    step(2);
    check("c21_state", 32'(dbg1.state), 32'(ERR));
    check("c21_ferr",  32'(ferr1), 32'h1);
    check("c21_eaddr", eaddr1, 32'h0100_1000);
    check("c21_ov",    32'(ov1), 32'h0);
    s = n_stb1;
    step(3);
    check("err_hold_ferr", 32'(ferr1), 32'h1);
    check("err_nstb",      32'(n_stb1), 32'(s));

    // redirect while in ERR moves pc only; err_clr resumes
    rv1 = 1'b1; rpc1 = 32'h0100_0008;
    step(); rv1 = 1'b0;
    check("errrd_state", 32'(dbg1.state), 32'(ERR));
    check("errrd_ferr",  32'(ferr1), 32'h1);
    ec1 = 1'b1;
    step(); ec1 = 1'b0;
    check("clr_state", 32'(dbg1.state), 32'(IDLE));
    check("clr_ferr",  32'(ferr1), 32'h0);
    step(); check("res_addr", bus1.instr_Raddr, 32'h0100_0008);
    check("res_ival", 32'(bus1.I_valid), 32'h1);
    step(2); check("res_oi", oi1, 32'h0008_FFF7);
    check("res_opc", opc1, 32'h0100_0008);

    // misaligned target
    step(); rv1 = 1'b1; rpc1 = 32'h0100_0002;
    step(); rv1 = 1'b0;
    check("mis_inrange", 32'(dbg1.pc_in_range), 32'h0);
    step();
`ifdef IM_FETCH_BOUND_CHK_EN
    check("mis_ival", 32'(bus1.I_valid), 32'h0);
    step();
`else
    check("mis_ival", 32'(bus1.I_valid), 32'h1);
    check("mis_addr", bus1.instr_Raddr, 32'h0100_0002);
    step(2);
`endif
    check("mis_state", 32'(dbg1.state), 32'(ERR));
    check("mis_ferr",  32'(ferr1), 32'h1);
    check("mis_eaddr", eaddr1, 32'h0100_0002);
    fe1 = 1'b0; ec1 = 1'b1;
    step(); ec1 = 1'b0;
    check("end1_state", 32'(dbg1.state), 32'(IDLE));

    // RSP_LAT=3 instance: 4-cycle strobe-to-valid, 5-cycle spacing
    check("l3_idle", 32'(n_stb3), 32'd0);
    fe3 = 1'b1;
    step(); check("l3_ival0", 32'(bus3.I_valid), 32'h1);
    check("l3_addr0", bus3.instr_Raddr, 32'h0100_0000);
    step(3); check("l3_ov_early", 32'(ov3), 32'h0);
    step(); check("l3_ov", 32'(ov3), 32'h1);
    check("l3_oi",  oi3, 32'hDEAD_BEEF);
    check("l3_opc", opc3, 32'h0100_0000);
    step(); check("l3_ival1", 32'(bus3.I_valid), 32'h1);
    check("l3_addr1", bus3.instr_Raddr, 32'h0100_0004);
    step(); fe3 = 1'b0;
    step(2); check("l3_ov1_early", 32'(ov3), 32'h0);
    step(); check("l3_ov1", 32'(ov3), 32'h1);
    check("l3_oi1",  oi3, 32'h0004_FFFB);
    check("l3_opc1", opc3, 32'h0100_0004);
    step(); check("l3_state", 32'(dbg3.state), 32'(IDLE));
    check("l3_ov_clr", 32'(ov3), 32'h0);
    step(2); check("l3_nstb", 32'(n_stb3), 32'd2);
    check("l3_ferr", 32'(ferr3), 32'h0);
    check("l3_eaddr", eaddr3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
